sram_cmd_sequencer: RTL and testbench

// - Upstream command stage for sram_top. Accepts parallel write/read requests on a valid/ready interface.
// - Serializes write data MSB-first onto sram_top's serial_in/shift pins, then pulses w_en.
// - Issues r_en for reads and captures data_out on data_valid; a timeout covers a missing data_valid.
// - Returns one response per request. Replaces hand-driven serial stimulus with a reusable front end.

---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_piso.sv | 48 ++++
 rtl/sram_cmd_sequencer.sv | 174 +++++++++++++++++
 tb/tb_sram_cmd_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the SRAM command sequencer
//
// Purpose : sequencer state encoding and request opcodes.
// Ports   : none (package).

package sram_pkg;

    // Sequencer states, in transaction order.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        WAIT  = 3'd4,
        RESP  = 3'd5
    } state_t;

    // Request opcodes carried on req_we.
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/sram_piso.sv
// rtl/sram_piso.sv - parallel-load, MSB-first shift register with bit counter
//
// Purpose : holds one write word and presents it one bit per enabled cycle,
//           MSB first, flagging the cycle in which the last bit is presented.
// Ports   : clk, srst  - clock, synchronous active-high reset
//           load       - capture din and restart the bit counter
//           en         - advance to the next bit at this edge
//           din        - parallel word
//           sout       - current bit (register MSB)
//           done       - en is high and the last bit is currently on sout

module sram_piso #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  load,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  sout,
    output logic                  done
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CW-1:0]         r_cnt;

    // Zeros are shifted in behind the word, so once all bits have gone out
    // (or nothing was ever loaded) sout is 0 with no extra gating needed.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_shreg <= din;
            r_cnt   <= '0;
        end else if (en) begin
            r_shreg <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign sout = r_shreg[DATA_WIDTH-1];
    assign done = en && (r_cnt == LAST_BIT);

endmodule

// File: rtl/sram_cmd_sequencer.sv
// rtl/sram_cmd_sequencer.sv - request/response front end driving sram_top serial write and read pins
//
// Purpose : accepts one write/read request at a time, serialises write data
//           MSB first onto serial_out/shift, pulses w_en or r_en, captures
//           read data on data_valid (with a timeout) and returns one
//           response per accepted request.
// Ports   : clk, srst                       - clock, synchronous active-high reset
//           req_valid/req_ready             - request handshake
//           req_we, req_addr, req_wdata     - request payload
//           rsp_valid, rsp_rdata, rsp_timeout - response (rsp_valid is a 1-cycle pulse)
//           serial_out, shift, w_en, r_en, addr - to sram_top
//           data_valid, data_in             - from sram_top

module sram_cmd_sequencer
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  serial_out,
    output logic                  shift,
    output logic                  w_en,
    output logic                  r_en,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_in
);

    localparam int WCW = $clog2(RD_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(RD_TIMEOUT - 1);
    localparam logic [WCW-1:0] WAIT_MAX  = WCW'(RD_TIMEOUT);

    state_t                r_state;
    state_t                w_next;

    logic                  r_req_ready;
    logic                  r_shift;
    logic                  r_w_en;
    logic                  r_r_en;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_timeout;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WCW-1:0]        r_wait_cnt;

    logic                  w_accept;
    logic                  w_piso_load;
    logic                  w_piso_en;
    logic                  w_piso_sout;
    logic                  w_piso_done;
    logic                  w_wait_expired;

    // req_ready is itself a register, so the first IDLE cycle after reset
    // cannot accept; gating on it keeps the handshake honest.
    assign w_accept       = (r_state == IDLE) && r_req_ready && req_valid;
    assign w_piso_load    = w_accept && (req_we == OP_WR);
    assign w_piso_en      = (r_state == SHIFT);
    // True on the RD_TIMEOUT-th WAIT cycle without data_valid.
    assign w_wait_expired = (r_wait_cnt >= WAIT_LAST);

    // The shift register doubles as the write-data latch: it is loaded on
    // accept and its MSB is the registered serial_out.
    sram_piso #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_piso (
        .clk  (clk),
        .srst (srst),
        .load (w_piso_load),
        .en   (w_piso_en),
        .din  (req_wdata),
        .sout (w_piso_sout),
        .done (w_piso_done)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (req_we == OP_WR) ? SHIFT : READ;
                end
            end
            SHIFT: begin
                if (w_piso_done) begin
                    w_next = WRITE;
                end
            end
            WRITE:   w_next = RESP;
            READ:    w_next = WAIT;
            WAIT: begin
                if (data_valid || w_wait_expired) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Pin-level outputs are decoded from the next state and registered, so
    // each strobe is glitch-free and aligned with the state it belongs to.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state       <= IDLE;
            r_req_ready   <= 1'b0;
            r_shift       <= 1'b0;
            r_w_en        <= 1'b0;
            r_r_en        <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
            r_addr        <= '0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == IDLE);
            r_shift     <= (w_next == SHIFT);
            r_w_en      <= (w_next == WRITE);
            r_r_en      <= (w_next == READ);
            r_rsp_valid <= (w_next == RESP);

            if (w_accept) begin
                r_addr <= req_addr;
            end

            // Response payload changes only when a response is being formed
            // and then holds until the next one.
            if (r_state == WRITE) begin
                r_rsp_rdata   <= '0;
                r_rsp_timeout <= 1'b0;
            end else if (r_state == WAIT) begin
                if (data_valid) begin
                    r_rsp_rdata   <= data_in;
                    r_rsp_timeout <= 1'b0;
                end else if (w_wait_expired) begin
                    r_rsp_rdata   <= '0;
                    r_rsp_timeout <= 1'b1;
                end
            end
        end
    end

    // Cleared during the r_en cycle, counts empty WAIT cycles, saturates.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wait_cnt <= '0;
        end else if (r_state == READ) begin
            r_wait_cnt <= '0;
        end else if ((r_state == WAIT) && !data_valid && (r_wait_cnt != WAIT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
        end
    end

    assign req_ready   = r_req_ready;
    assign shift       = r_shift;
    assign serial_out  = w_piso_sout;
    assign w_en        = r_w_en;
    assign r_en        = r_r_en;
    assign addr        = r_addr;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_sram_cmd_sequencer.sv
// tb/tb_sram_cmd_sequencer.sv - self-checking bench for sram_cmd_sequencer with a behavioural sram_top

module tb_sram_cmd_sequencer;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          srst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_timeout;
    logic          serial_out;
    logic          shift;
    logic          w_en;
    logic          r_en;
    logic [AW-1:0] addr;
    logic          data_valid;
    logic [DW-1:0] data_in;

    sram_cmd_sequencer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .serial_out  (serial_out),
        .shift       (shift),
        .w_en        (w_en),
        .r_en        (r_en),
        .addr        (addr),
        .data_valid  (data_valid),
        .data_in     (data_in)
    );

    // Behavioural sram_top: serial shift-in, word write on w_en, read data
    // returned cfg_lat cycles after r_en (or never when cfg_block is set).
    logic [DW-1:0] m_mem [2**AW];
    logic [DW-1:0] m_sreg;
    logic [DW-1:0] m_q;
    logic          m_dv;
    logic          m_pend;
    int            m_pcnt;
    logic          m_clear;
    int            cfg_lat;
    logic          cfg_block;
    logic          inj_dv;
    logic [DW-1:0] inj_data;

    assign data_valid = m_dv | inj_dv;
    assign data_in    = m_dv ? m_q : inj_data;

    always @(posedge clk) begin
        if (m_clear) begin
            for (int i = 0; i < 2**AW; i++) m_mem[i] <= '0;
            m_sreg <= '0;
            m_q    <= '0;
            m_dv   <= 1'b0;
            m_pend <= 1'b0;
            m_pcnt <= 0;
        end else begin
            m_dv <= 1'b0;
            if (shift) m_sreg <= {m_sreg[DW-2:0], serial_out};
            if (w_en) m_mem[addr] <= m_sreg;
            if (r_en) begin
                if (cfg_lat == 0) begin
                    m_dv <= !cfg_block;
                    m_q  <= m_mem[addr];
                end else begin
                    m_pend <= 1'b1;
                    m_pcnt <= cfg_lat - 1;
                end
            end else if (m_pend) begin
                if (m_pcnt == 0) begin
                    m_dv   <= !cfg_block;
                    m_q    <= m_mem[addr];
                    m_pend <= 1'b0;
                end else begin
                    m_pcnt <= m_pcnt - 1;
                end
            end
        end
    end

    int rsp_seen = 0;
    always @(posedge clk) begin
        if (rsp_valid === 1'b1) rsp_seen <= rsp_seen + 1;
    end

    int            checks = 0;
    int            failures = 0;
    int            exp_rsp = 0;
    logic [DW-1:0] ref_mem [2**AW];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] all_out();
        return {req_ready, rsp_valid, rsp_timeout, rsp_rdata, serial_out, shift, w_en, r_en, addr};
    endfunction

    // One request, checked cycle by cycle against the expected schedule
    // derived from the accept edge T. Returns on the negedge of cycle T+rk+1.
    task automatic run_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int lat, input logic block, input int inj_k,
                           input logic keep_valid, input string tag);
        int            rk;
        bit            got;
        logic [DW-1:0] exp_rd;
        logic          exp_to;
        logic          e_rdy, e_sh, e_so, e_we, e_re, e_rv;
        cfg_lat   = lat;
        cfg_block = block;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            chk($sformatf("%s_accept", tag), 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_rsp++;
        if (we) begin
            rk = DW + 2; exp_rd = '0; exp_to = 1'b0;
            ref_mem[a] = d;
        end else if (block) begin
            rk = TO + 2; exp_rd = '0; exp_to = 1'b1;
        end else begin
            rk = 3 + lat; exp_rd = ref_mem[a]; exp_to = 1'b0;
        end
        for (int k = 1; k <= rk + 1; k++) begin
            @(negedge clk);
            if (k == 1 && !keep_valid) req_valid = 1'b0;
            e_rdy = (k == rk + 1);
            e_sh  = we && (k <= DW);
            e_so  = e_sh ? d[DW-k] : 1'b0;
            e_we  = we && (k == DW + 1);
            e_re  = !we && (k == 1);
            e_rv  = (k == rk);
            chk($sformatf("%s_cyc%0d", tag, k),
                {req_ready, shift, serial_out, w_en, r_en, rsp_valid, addr},
                {e_rdy, e_sh, e_so, e_we, e_re, e_rv, a});
            if (k == rk) begin
                chk($sformatf("%s_rdata", tag), rsp_rdata, exp_rd);
                chk($sformatf("%s_timeout", tag), rsp_timeout, exp_to);
            end
            if (k == rk + 1) chk($sformatf("%s_rdata_hold", tag), rsp_rdata, exp_rd);
            if (inj_k > 0 && k == inj_k) begin
                inj_dv = 1'b1;
                inj_data = 8'h77;
            end
            if (inj_k > 0 && k == inj_k + 1) inj_dv = 1'b0;
        end
        inj_dv = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          r_we;
        logic [AW-1:0] r_a;
        logic [DW-1:0] r_d;
        int            r_lat;
        logic          r_blk;
        logic          r_keep;
        int            r_inj;

        srst      = 1'b1;
        m_clear   = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        inj_dv    = 1'b0;
        inj_data  = '0;
        cfg_lat   = 0;
        cfg_block = 1'b0;
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;

        // Power-on reset.
        repeat (3) @(negedge clk);
        chk("por_outputs", all_out(), 19'd0);
        srst    = 1'b0;
        m_clear = 1'b0;
        @(negedge clk);
        chk("por_release", all_out(), {1'b1, 18'd0});

        // Reset two cycles in the middle of shifting 0xA5 to address 3.
        req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_shift", {shift, addr}, {1'b1, 4'd3});
        srst = 1'b1;
        @(negedge clk);
        chk("rst_cycle1", all_out(), 19'd0);
        @(negedge clk);
        chk("rst_cycle2", all_out(), 19'd0);
        srst = 1'b0;
        @(negedge clk);
        chk("rst_release", all_out(), {1'b1, 18'd0});
        repeat (DW + 4) @(negedge clk);
        chk("rst_quiet", {req_ready, rsp_valid, shift, w_en, r_en}, 5'b10000);
        chk("rst_no_commit", m_mem[3], 8'h00);
        chk("rst_no_rsp", rsp_seen, 32'd0);

        // Stray data_valid while idle.
        inj_dv = 1'b1; inj_data = 8'h77;
        @(negedge clk);
        inj_dv = 1'b0;
        chk("stray_idle1", {req_ready, rsp_valid, shift, w_en, r_en, rsp_rdata}, {5'b10000, 8'h00});
        @(negedge clk);
        chk("stray_idle2", {req_ready, rsp_valid, shift, w_en, r_en, rsp_rdata}, {5'b10000, 8'h00});

        // Directed write and read-back.
        run_txn(1'b1, 4'd3, 8'hA5, 0, 1'b0, 0, 1'b0, "wr_a5");
        run_txn(1'b0, 4'd3, 8'h00, 0, 1'b0, 0, 1'b0, "rd_a5");

        // Back-to-back with req_valid held high.
        run_txn(1'b1, 4'd1,  8'h3C, 0, 1'b0, 0, 1'b1, "b2b_w1");
        run_txn(1'b1, 4'd15, 8'hFF, 0, 1'b0, 0, 1'b1, "b2b_w15");
        run_txn(1'b0, 4'd1,  8'h00, 1, 1'b0, 0, 1'b1, "b2b_r1");
        run_txn(1'b0, 4'd15, 8'h00, 2, 1'b0, 0, 1'b0, "b2b_r15");

        // Read with data_valid withheld.
        run_txn(1'b0, 4'd3, 8'h00, 0, 1'b1, 0, 1'b0, "rd_timeout");

        // Stray data_valid during SHIFT.
        run_txn(1'b1, 4'd7, 8'h5A, 0, 1'b0, 3, 1'b0, "wr_stray");
        run_txn(1'b0, 4'd7, 8'h00, 3, 1'b0, 0, 1'b0, "rd_stray");

        // Randomised traffic against the reference memory.
        for (int n = 0; n < 24; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_a    = AW'($urandom_range(0, 2**AW - 1));
            r_d    = DW'($urandom);
            r_lat  = $urandom_range(0, 3);
            r_blk  = !r_we && ($urandom_range(0, 7) == 0);
            r_keep = (n < 23) && ($urandom_range(0, 1) == 1);
            r_inj  = r_we ? $urandom_range(0, DW) : 0;
            run_txn(r_we, r_a, r_d, r_lat, r_blk, r_inj, r_keep, $sformatf("rnd%0d", n));
        end

        repeat (3) @(negedge clk);
        chk("rsp_count", rsp_seen, exp_rsp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
